mbus_arbiter: RTL and testbench

//  Shares the single processor memory bus (address, write data, write enable, read data) between NREQ masters.

---
 rtl/mbus_arbiter_pkg.sv | 18 +
 rtl/mbus_arbiter_rr_pick.sv | 31 +++
 rtl/mbus_arbiter.sv | 140 ++++++++++++++
 tb/tb_mbus_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbus_arbiter_pkg.sv
// Shared definitions for the memory-bus arbiter: FSM state codes and the
// master-count bound that sizes the owner debug port.
package mbus_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int MAX_MASTERS = 8;
    localparam int OWNER_W     = $clog2(MAX_MASTERS);

    // Pointer advance with an explicit wrap compare so NREQ need not be a power of two.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mbus_arbiter_rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping N-1 -> 0.
// Purely combinational so it can be reused by other request arbiters.
module rr_pick #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        int pos;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        pos = 0;
        for (int off = 0; off < N; off++) begin
            pos = int'(ptr) + off;
            if (pos >= N) pos = pos - N;
            if (!any && req[PW'(pos)]) begin
                any            = 1'b1;
                gnt[PW'(pos)]  = 1'b1;
                idx            = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/mbus_arbiter.sv
// Per-cycle arbiter sharing one processor memory bus between NREQ masters,
// with optional master-0 priority, bounded lock bursts and read-valid strobes.
//
//   state      | meaning
//   ARB_IDLE   | round-robin (or master-0 priority) pick every cycle
//   ARB_LOCKED | lk_idx keeps the bus while it requests+locks, up to LOCK_MAX cycles
module mbus_arbiter
    import mbus_arbiter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NREQ     = 3,
    parameter int PRIO0    = 0,
    parameter int READ_LAT = 1,
    parameter int LOCK_MAX = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         m_req,
    input  logic [NREQ-1:0]         m_lock,
    input  logic [NREQ-1:0]         m_wen,
    input  logic [NREQ*WIDTH-1:0]   m_addr,
    input  logic [NREQ*WIDTH-1:0]   m_dout,
    output logic [NREQ-1:0]         m_gnt,
    output logic [NREQ-1:0]         m_rvalid,
    output logic [WIDTH-1:0]        m_din,
    output logic [WIDTH-1:0]        bus_aout,
    output logic [WIDTH-1:0]        bus_dout,
    output logic                    bus_wen,
    input  logic [WIDTH-1:0]        bus_din,
    output logic [OWNER_W-1:0]      owner
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_t        state, state_nxt;
    logic [PW-1:0]     ptr, ptr_nxt;
    logic [PW-1:0]     lk_idx, lk_idx_nxt;
    logic [CW-1:0]     lock_cnt, lock_cnt_nxt;
    logic [OWNER_W-1:0] owner_q;

    logic [NREQ-1:0]   rr_gnt, gnt;
    logic [PW-1:0]     rr_idx, gidx;
    logic              rr_any, gany;
    logic              hold;

    rr_pick #(.N(NREQ), .PW(PW)) u_rr_pick (
        .req (m_req),
        .ptr (ptr),
        .gnt (rr_gnt),
        .idx (rr_idx),
        .any (rr_any)
    );

    // Ptr already points past lk_idx while locked, so an exit cycle arbitrates from g+1.
    assign hold = (state == ARB_LOCKED) && m_req[lk_idx] && m_lock[lk_idx]
                  && (lock_cnt < CW'(LOCK_MAX));

    always_comb begin
        gnt          = '0;
        gidx         = '0;
        gany         = 1'b0;
        state_nxt    = state;
        ptr_nxt      = ptr;
        lk_idx_nxt   = lk_idx;
        lock_cnt_nxt = lock_cnt;
        if (hold) begin
            gnt[lk_idx]  = 1'b1;
            gidx         = lk_idx;
            gany         = 1'b1;
            lock_cnt_nxt = lock_cnt + CW'(1);
        end else begin
            if (PRIO0 != 0 && m_req[0]) begin
                gnt[0] = 1'b1;
                gidx   = '0;
                gany   = 1'b1;
            end else begin
                gnt  = rr_gnt;
                gidx = rr_idx;
                gany = rr_any;
            end
            state_nxt    = ARB_IDLE;
            lock_cnt_nxt = '0;
            if (gany) begin
                ptr_nxt = PW'(wrap_inc(int'(gidx), NREQ));
                if (m_lock[gidx]) begin
                    state_nxt    = ARB_LOCKED;
                    lock_cnt_nxt = CW'(1);
                    lk_idx_nxt   = gidx;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_IDLE;
            ptr      <= '0;
            lk_idx   <= '0;
            lock_cnt <= '0;
            owner_q  <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            lk_idx   <= lk_idx_nxt;
            lock_cnt <= lock_cnt_nxt;
            if (gany) owner_q <= OWNER_W'(gidx);
        end
    end

    always_comb begin
        bus_aout = '0;
        bus_dout = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                bus_aout = bus_aout | m_addr[i*WIDTH +: WIDTH];
                bus_dout = bus_dout | m_dout[i*WIDTH +: WIDTH];
            end
        end
    end

    assign bus_wen = |(gnt & m_wen);
    assign m_gnt   = gnt;
    assign m_din   = bus_din;
    assign owner   = gany ? OWNER_W'(gidx) : owner_q;

    generate
        if (READ_LAT == 0) begin : g_rv_comb
            assign m_rvalid = gnt & ~m_wen;
        end else begin : g_rv_reg
            logic [NREQ-1:0] rvalid_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) rvalid_q <= '0;
                else       rvalid_q <= gnt & ~m_wen;
            end
            assign m_rvalid = rvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_mbus_arbiter.sv
// Scoreboard bench: two arbiters (round-robin and master-0 priority) checked
// against a rule-level reference model, with a small memory slave per arbiter.
module tb_mbus_arbiter;

    localparam int W  = 32;
    localparam int NR = 3;
    localparam int LM = 8;

    typedef struct {
        logic [1:0][2:0]  gnt;
        logic [1:0][31:0] aout;
        logic [1:0][31:0] dout;
        logic [1:0]       wen;
        logic [1:0][2:0]  own;
    } gexp_t;

    typedef struct {
        int          due;
        logic [2:0]  rv;
        logic [31:0] data;
    } rexp_t;

    logic clk = 1'b0;
    logic reset;
    logic load_en;
    logic [2:0]  req_i [2];
    logic [2:0]  lock_i [2];
    logic [2:0]  wen_i [2];
    logic [95:0] addr_i [2];
    logic [95:0] dout_i [2];
    logic [31:0] din_i [2];
    logic [2:0]  gnt_o [2];
    logic [2:0]  rv_o [2];
    logic [2:0]  own_o [2];
    logic [31:0] mdin_o [2];
    logic [31:0] aout_o [2];
    logic [31:0] bdout_o [2];
    logic        bwen_o [2];
    logic [31:0] smem [2][16];

    gexp_t gq[$];
    rexp_t rq0[$], rq1[$];
    gexp_t cur_e;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int ptr [2], bo [2], blen [2], last_own [2], last_g [2];
    logic [31:0] mmem [2][16];

    bit          pend [2][3];
    int          burst [2][3];
    logic [31:0] pa [2][3], pd [2][3];
    bit          pw [2][3];

    always #5 clk = ~clk;

    mbus_arbiter #(.WIDTH(W), .NREQ(NR), .PRIO0(0), .READ_LAT(1), .LOCK_MAX(LM)) dut0 (
        .clk(clk), .reset(reset), .m_req(req_i[0]), .m_lock(lock_i[0]), .m_wen(wen_i[0]),
        .m_addr(addr_i[0]), .m_dout(dout_i[0]), .m_gnt(gnt_o[0]), .m_rvalid(rv_o[0]),
        .m_din(mdin_o[0]), .bus_aout(aout_o[0]), .bus_dout(bdout_o[0]), .bus_wen(bwen_o[0]),
        .bus_din(din_i[0]), .owner(own_o[0])
    );

    mbus_arbiter #(.WIDTH(W), .NREQ(NR), .PRIO0(1), .READ_LAT(1), .LOCK_MAX(LM)) dut1 (
        .clk(clk), .reset(reset), .m_req(req_i[1]), .m_lock(lock_i[1]), .m_wen(wen_i[1]),
        .m_addr(addr_i[1]), .m_dout(dout_i[1]), .m_gnt(gnt_o[1]), .m_rvalid(rv_o[1]),
        .m_din(mdin_o[1]), .bus_aout(aout_o[1]), .bus_dout(bdout_o[1]), .bus_wen(bwen_o[1]),
        .bus_din(din_i[1]), .owner(own_o[1])
    );

    // Memory slave with one cycle of read latency.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (load_en) begin
                for (int j = 0; j < 16; j++) smem[i][j] <= (j == 5) ? 32'hDEADBEEF : 32'h0;
            end else begin
                if (bwen_o[i]) smem[i][aout_o[i][3:0]] <= bdout_o[i];
                din_i[i] <= smem[i][aout_o[i][3:0]];
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h", nm, i, cyc, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int pick(input logic [2:0] req, input int start, input bit prio);
        if (prio && req[0]) return 0;
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (start + k) % NR;
            if (req[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ptr[i] = 0; bo[i] = -1; blen[i] = 0; last_own[i] = 0; last_g[i] = -1;
        end
    endtask

    task automatic model_step(input int i);
        int g;
        logic [31:0] a;
        rexp_t r;
        if (bo[i] >= 0 && req_i[i][bo[i]] && lock_i[i][bo[i]] && blen[i] < LM) begin
            g = bo[i];
            blen[i]++;
        end else begin
            if (bo[i] >= 0) ptr[i] = (bo[i] + 1) % NR;
            bo[i] = -1;
            blen[i] = 0;
            g = pick(req_i[i], ptr[i], i == 1);
            if (g >= 0) begin
                if (lock_i[i][g]) begin
                    bo[i] = g;
                    blen[i] = 1;
                end else begin
                    ptr[i] = (g + 1) % NR;
                end
            end
        end
        last_g[i] = g;
        if (g >= 0) begin
            a = addr_i[i][g*32 +: 32];
            cur_e.gnt[i]  = 3'(1 << g);
            cur_e.aout[i] = a;
            cur_e.dout[i] = dout_i[i][g*32 +: 32];
            cur_e.wen[i]  = wen_i[i][g];
            last_own[i]   = g;
            if (wen_i[i][g]) begin
                mmem[i][a[3:0]] = dout_i[i][g*32 +: 32];
            end else begin
                r.due = cyc + 1;
                r.rv = 3'(1 << g);
                r.data = mmem[i][a[3:0]];
                if (i == 0) rq0.push_back(r);
                else rq1.push_back(r);
            end
        end else begin
            cur_e.gnt[i]  = 3'b000;
            cur_e.aout[i] = 32'h0;
            cur_e.dout[i] = 32'h0;
            cur_e.wen[i]  = 1'b0;
        end
        cur_e.own[i] = 3'(last_own[i]);
    endtask

    task automatic step_cycle();
        model_step(0);
        model_step(1);
        gq.push_back(cur_e);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- monitor ----------------
    task automatic mon_rv(input int i);
        rexp_t r;
        int sz;
        sz = (i == 0) ? rq0.size() : rq1.size();
        if (sz > 0) begin
            r = (i == 0) ? rq0[0] : rq1[0];
            if (r.due < cyc) begin
                chk("rvalid_missing", i, 32'(rv_o[i]), 32'(r.rv));
                if (i == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
                sz--;
            end
        end
        if (rv_o[i] != 3'b000) begin
            if (sz > 0) r = (i == 0) ? rq0[0] : rq1[0];
            if (sz > 0 && r.due == cyc) begin
                chk("rvalid", i, 32'(rv_o[i]), 32'(r.rv));
                chk("rdata", i, mdin_o[i], r.data);
                if (i == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
            end else begin
                chk("rvalid_spurious", i, 32'(rv_o[i]), 32'h0);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (gq.size() > 0) begin
                gexp_t e;
                e = gq.pop_front();
                for (int i = 0; i < 2; i++) begin
                    chk("gnt", i, 32'(gnt_o[i]), 32'(e.gnt[i]));
                    chk("bus_aout", i, aout_o[i], e.aout[i]);
                    chk("bus_dout", i, bdout_o[i], e.dout[i]);
                    chk("bus_wen", i, 32'(bwen_o[i]), 32'(e.wen[i]));
                    chk("owner", i, 32'(own_o[i]), 32'(e.own[i]));
                end
            end
            mon_rv(0);
            mon_rv(1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_all(input logic [2:0] req, input logic [2:0] lock, input logic [2:0] wen,
                           input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                           input logic [31:0] d);
        for (int i = 0; i < 2; i++) begin
            req_i[i]  = req;
            lock_i[i] = lock;
            wen_i[i]  = wen;
            addr_i[i] = {a2, a1, a0};
            dout_i[i] = {d ^ 32'h2, d ^ 32'h1, d};
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_all(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
        gq.delete();
        rq0.delete();
        rq1.delete();
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst_gnt", i, 32'(gnt_o[i]), 32'h0);
            chk("rst_rvalid", i, 32'(rv_o[i]), 32'h0);
            chk("rst_wen", i, 32'(bwen_o[i]), 32'h0);
            chk("rst_owner", i, 32'(own_o[i]), 32'h0);
        end
        model_reset();
        for (int i = 0; i < 2; i++)
            for (int m = 0; m < 3; m++) pend[i][m] = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic new_op(input int i, input int m);
        pa[i][m] = 32'($urandom_range(0, 15));
        pd[i][m] = $urandom;
        pw[i][m] = 1'($urandom_range(0, 1));
    endtask

    task automatic gen_in(input int i);
        for (int m = 0; m < 3; m++) begin
            if (!pend[i][m] && $urandom_range(0, 2) == 0) begin
                pend[i][m]  = 1'b1;
                burst[i][m] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 12)) : 1;
                new_op(i, m);
            end
            req_i[i][m]  = pend[i][m];
            lock_i[i][m] = pend[i][m] && burst[i][m] > 1 && ($urandom_range(0, 9) != 0);
            wen_i[i][m]  = pw[i][m];
            addr_i[i][m*32 +: 32] = pa[i][m];
            dout_i[i][m*32 +: 32] = pd[i][m];
        end
    endtask

    task automatic post_in(input int i);
        int g;
        g = last_g[i];
        if (g >= 0) begin
            burst[i][g]--;
            if (burst[i][g] <= 0) pend[i][g] = 1'b0;
            else new_op(i, g);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 16; j++) mmem[i][j] = (j == 5) ? 32'hDEADBEEF : 32'h0;
        reset   = 1'b1;
        load_en = 1'b1;
        set_all(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        load_en = 1'b0;
        do_reset();

        // all three requesting, no lock, reads
        for (int k = 0; k < 6; k++) begin
            set_all(3'b111, 3'b000, 3'b000, 32'h1, 32'h2, 32'h3, 32'h0);
            step_cycle();
        end
        // master-0 priority then drop m_req[0]
        for (int k = 0; k < 4; k++) begin
            set_all(3'b111, 3'b000, 3'b111, 32'h8, 32'h9, 32'hA, 32'h100 + 32'(k));
            step_cycle();
        end
        for (int k = 0; k < 2; k++) begin
            set_all(3'b110, 3'b000, 3'b000, 32'h8, 32'h9, 32'hA, 32'h0);
            step_cycle();
        end

        // master 1 lock with master 2 waiting: forced release after LOCK_MAX
        do_reset();
        for (int k = 0; k < 12; k++) begin
            set_all(3'b110, 3'b010, 3'b000, 32'h1, 32'h4, 32'h6, 32'h0);
            step_cycle();
        end

        // master 2 read of 0x5, write to 0x5, read back
        set_all(3'b100, 3'b000, 3'b000, 32'h0, 32'h0, 32'h5, 32'h0);
        step_cycle();
        set_all(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
        step_cycle();
        set_all(3'b100, 3'b000, 3'b100, 32'h0, 32'h0, 32'h5, 32'h12345678);
        step_cycle();
        set_all(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
        step_cycle();
        set_all(3'b100, 3'b000, 3'b000, 32'h0, 32'h0, 32'h5, 32'h0);
        step_cycle();

        // idle bus
        for (int k = 0; k < 3; k++) begin
            set_all(3'b000, 3'b000, 3'b000, 32'h7, 32'h7, 32'h7, 32'hFFFF);
            step_cycle();
        end

        // reset while master 0 locked with a read outstanding
        for (int k = 0; k < 3; k++) begin
            set_all(3'b001, 3'b001, 3'b000, 32'h5, 32'h0, 32'h0, 32'h0);
            step_cycle();
        end
        do_reset();
        set_all(3'b110, 3'b000, 3'b000, 32'h0, 32'h3, 32'h4, 32'h0);
        step_cycle();

        // randomized traffic
        set_all(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
        step_cycle();
        for (int k = 0; k < 1500; k++) begin
            if (k == 750) do_reset();
            gen_in(0);
            gen_in(1);
            model_step(0);
            model_step(1);
            gq.push_back(cur_e);
            post_in(0);
            post_in(1);
            @(posedge clk);
            #1;
            cyc++;
        end

        set_all(3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step_cycle();
        @(negedge clk);
        #1;
        chk("rq0_drained", 0, 32'(rq0.size()), 32'h0);
        chk("rq1_drained", 1, 32'(rq1.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
